// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Multi-cycle multiply/divide unit producing the architectural
//                HI/LO pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//                Operands are latched on the start edge; the result is
//                written to HI/LO on the edge where the busy counter
//                reaches zero.
//  Ports       : clk      - rising-edge clock
//                reset    - synchronous, active-low reset
//                start    - operation request (ignored while busy)
//                mdop     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//                rs_data  - operand A / MTHI-MTLO source
//                rt_data  - operand B / divisor
//                busy     - mult/div in flight
//                hi, lo   - architectural HI/LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CW   = $clog2(c_MAXC + 1);

    localparam logic [c_CW-1:0] c_MULT_LOAD = c_CW'(MULT_CYCLES);
    localparam logic [c_CW-1:0] c_DIV_LOAD  = c_CW'(DIV_CYCLES);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [2:0] c_OP_MTHI = 3'd4;
    localparam logic [2:0] c_OP_MTLO = 3'd5;

    logic [0:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_op;      // bit1: divide, bit0: unsigned
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    // Signed ops are done as sign/magnitude so one unsigned multiplier and
    // one unsigned divider serve both signednesses. The magnitude of
    // 0x80000000 is 0x80000000 as an unsigned value, which makes the
    // 0x80000000 / -1 case fall out naturally (quotient 0x80000000, rem 0).
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_prod_mag;
    logic [63:0] w_prod;
    logic [31:0] w_div_b;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_div_zero;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    always_comb begin
        w_sa       = r_a[31] & ~r_op[0];
        w_sb       = r_b[31] & ~r_op[0];
        w_mag_a    = w_sa ? (32'd0 - r_a) : r_a;
        w_mag_b    = w_sb ? (32'd0 - r_b) : r_b;

        w_prod_mag = {32'd0, w_mag_a} * {32'd0, w_mag_b};
        w_prod     = (w_sa ^ w_sb) ? (64'd0 - w_prod_mag) : w_prod_mag;

        // Divisor forced non-zero so the divider never sees x/0; the result
        // is discarded in that case anyway.
        w_div_zero = r_op[1] & (r_b == 32'd0);
        w_div_b    = (r_b == 32'd0) ? 32'd1 : w_mag_b;
        w_q_mag    = w_mag_a / w_div_b;
        w_r_mag    = w_mag_a % w_div_b;
        w_q        = (w_sa ^ w_sb) ? (32'd0 - w_q_mag) : w_q_mag;
        w_r        = w_sa ? (32'd0 - w_r_mag) : w_r_mag;   // sign of dividend

        w_res_hi   = r_op[1] ? w_r : w_prod[63:32];
        w_res_lo   = r_op[1] ? w_q : w_prod[31:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (mdop[2] == 1'b0) begin
                            r_op    <= mdop[1:0];
                            r_a     <= rs_data;
                            r_b     <= rt_data;
                            r_cnt   <= mdop[1] ? c_DIV_LOAD : c_MULT_LOAD;
                            r_state <= c_RUN;
                        end else if (mdop == c_OP_MTHI) begin
                            r_hi <= rs_data;
                        end else if (mdop == c_OP_MTLO) begin
                            r_lo <= rs_data;
                        end
                    end
                end
                c_RUN: begin
                    r_cnt <= r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        r_state <= c_IDLE;
                        if (!w_div_zero) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (r_state == c_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu
//  Description : Self-checking bench for mdu. A transaction-level reference
//                model computes each result with plain arithmetic at the
//                start edge and counts down the busy time; outputs are
//                compared against it every cycle, plus literal checks of
//                the directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

    localparam int c_MULT = 5;
    localparam int c_DIV  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu #(.MULT_CYCLES(c_MULT), .DIV_CYCLES(c_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdop    (mdop),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void compute(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] rh,
                                    output logic [31:0] rl, output bit ok);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        int              ia, ib;
        ok = 1'b1;
        rh = 32'd0;
        rl = 32'd0;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sp = sa * sb;
                rh = sp[63:32];
                rl = sp[31:0];
            end
            3'd1: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                up = ua * ub;
                rh = up[63:32];
                rl = up[31:0];
            end
            3'd2: begin
                if (b == 32'd0) ok = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000;
                    rh = 32'd0;
                end else begin
                    ia = a;
                    ib = b;
                    rl = ia / ib;
                    rh = ia % ib;
                end
            end
            3'd3: begin
                if (b == 32'd0) ok = 1'b0;
                else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            default: ok = 1'b0;
        endcase
    endfunction

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_left = 0;
    logic [31:0] m_ph, m_pl;
    bit          m_ok;

    always @(posedge clk) begin
        if (!reset) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
        end else if (m_left != 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_ok) begin
                m_hi = m_ph;
                m_lo = m_pl;
            end
        end else if (start) begin
            if (mdop <= 3'd3) begin
                compute(mdop, rs_data, rt_data, m_ph, m_pl, m_ok);
                m_left = (mdop < 3'd2) ? c_MULT : c_DIV;
            end else if (mdop == 3'd4) begin
                m_hi = rs_data;
            end else if (mdop == 3'd5) begin
                m_lo = rs_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start   = 1'b1;
        mdop    = op;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_cycles);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check(name, n, exp_cycles);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        mdop    = 3'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b1;

        issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle("mult_busy_len", c_MULT);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle("multu_busy_len", c_MULT);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle("div_busy_len", c_DIV);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(3'd3, 32'h0000_0007, 32'h0000_0002);
        wait_idle("divu_busy_len", c_DIV);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("divovf_busy_len", c_DIV);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        issue(3'd3, 32'h1234_0000, 32'd0);
        wait_idle("div0_busy_len", c_DIV);
        check("div0_lo", lo, 32'h8000_0000);
        check("div0_hi", hi, 32'd0);

        issue(3'd4, 32'h1234_5678, 32'd0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);

        // start pulse mid-run must be ignored
        issue(3'd1, 32'd3, 32'd4);
        start   = 1'b1;
        mdop    = 3'd5;
        rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        start   = 1'b0;
        wait_idle("ign_busy_len", c_MULT - 1);
        check("ign_lo", lo, 32'd12);
        check("ign_hi", hi, 32'd0);

        // reset at cycle 3 of a MULT drops the result
        issue(3'd4, 32'h5555_AAAA, 32'd0);
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rstrun_busy", {31'd0, busy}, 32'd0);
        check("rstrun_hi", hi, 32'd0);
        check("rstrun_lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        check("rstrun_late_hi", hi, 32'd0);
        check("rstrun_late_lo", lo, 32'd0);

        // randomized phase: continuous random requests, back-to-back starts,
        // ignored starts while busy, occasional reset
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 99) != 0);
            start   = ($urandom_range(0, 2) != 0);
            mdop    = 3'($urandom_range(0, 7));
            rs_data = pick();
            rt_data = pick();
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
